// File: rtl/seq_div_pkg.sv
// Shared arithmetic definitions for the sequential divider.
// FSM state encoding and counter sizing helper.
package seq_div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/seq_div_lcs.sv
// Ripple-borrow subtractor: d = a - b - bi, bo = borrow out.
// Same generate/propagate chain shape as the ripple-carry adder.
module lcs #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bi,
   output logic [WIDTH-1:0] d,
   output logic             bo
);

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;

   assign c[0] = bi;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_bit
         assign g[i]   = ~a[i] & b[i];
         assign p[i]   = ~(a[i] ^ b[i]);
         assign d[i]   = a[i] ^ b[i] ^ c[i];
         assign c[i+1] = g[i] | (p[i] & c[i]);
      end
   endgenerate

   assign bo = c[WIDTH];

endmodule

// File: rtl/seq_div.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle.
// Valid/ready handshakes on operand and result sides.
module seq_div
   import seq_div_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] d_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH:0]   rem_reg;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic [CW-1:0]    cnt;
   logic             dbz;
   logic             borrow;
   logic             accept;
   logic             zero_div;
   logic             last;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid & in_ready;
   assign zero_div  = (divisor == '0);
   assign last      = (cnt == CW'(WIDTH - 1));

   // Partial remainder shifted left, next dividend bit brought in.
   assign shifted = (rem_reg << 1)
                  | {{WIDTH{1'b0}}, q_reg[WIDTH-1]};

   lcs #(
      .WIDTH(WIDTH + 1)
   ) u_sub (
      .a  (shifted),
      .b  ({1'b0, d_reg}),
      .bi (1'b0),
      .d  (trial),
      .bo (borrow)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (in_valid) state_nx = zero_div ? DONE : BUSY;
         BUSY: if (last)      state_nx = DONE;
         DONE: if (out_ready) state_nx = IDLE;
         default:             state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         d_reg   <= '0;
         q_reg   <= '0;
         rem_reg <= '0;
         cnt     <= '0;
         dbz     <= 1'b0;
      end else if (accept) begin
         d_reg <= divisor;
         cnt   <= '0;
         dbz   <= zero_div;
         if (zero_div) begin
            q_reg   <= '1;
            rem_reg <= {1'b0, dividend};
         end else begin
            q_reg   <= dividend;
            rem_reg <= '0;
         end
      end else if (state == BUSY) begin
         rem_reg <= borrow ? shifted : trial;
         q_reg   <= {q_reg[WIDTH-2:0], ~borrow};
         cnt     <= cnt + 1'b1;
      end
   end

   assign quotient    = q_reg;
   assign remainder   = rem_reg[WIDTH-1:0];
   assign div_by_zero = dbz;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div at WIDTH=4.
// Directed cases plus a randomly stalled exhaustive sweep.
module tb_seq_div;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int total = 0;
   int bad   = 0;

   seq_div #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   // Reference: plain / and %, with the divide-by-zero rule.
   function automatic logic [2*W:0] ref_div(input int a, input int b);
      int q, r;
      logic z;
      if (b == 0) begin
         q = (1 << W) - 1; r = a; z = 1'b1;
      end else begin
         q = a / b; r = a % b; z = 1'b0;
      end
      return {z, W'(q), W'(r)};
   endfunction

   task automatic run_op(input int a, input int b, input int stall,
                         input bit noise);
      logic [2*W:0] e;
      int lat;
      e = ref_div(a, b);
      chk("idle_ready", in_ready, 1);
      in_valid  = 1'b1;
      dividend  = W'(a);
      divisor   = W'(b);
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      lat = 1;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      chk("latency", lat, (b == 0) ? 1 : W + 1);
      chk("quot", quotient, e[2*W-1:W]);
      chk("rem", remainder, e[W-1:0]);
      chk("dbz", div_by_zero, e[2*W]);
      for (int s = 0; s < stall; s++) begin
         if (noise) begin
            in_valid = 1'b1;
            dividend = W'($urandom);
            divisor  = W'($urandom);
         end
         step();
         chk("stall_valid", out_valid, 1);
         chk("stall_ready", in_ready, 0);
         chk("stall_quot", quotient, e[2*W-1:W]);
         chk("stall_rem", remainder, e[W-1:0]);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("post_valid", out_valid, 0);
      chk("post_ready", in_ready, 1);
   endtask

   logic [2*W:0] exq[$];
   logic [2*W:0] e;
   int idx, got, cyc;
   bit acc, con;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      dividend  = '0;
      divisor   = '0;
      out_ready = 1'b0;
      step();
      step();
      chk("rst_ready", in_ready, 1);
      chk("rst_valid", out_valid, 0);
      chk("rst_quot", quotient, 0);
      chk("rst_rem", remainder, 0);
      chk("rst_dbz", div_by_zero, 0);
      rst = 1'b0;
      step();

      run_op(13, 3, 0, 0);
      run_op(7, 0, 0, 0);
      run_op(15, 1, 0, 0);
      run_op(2, 5, 0, 0);
      run_op(15, 15, 0, 0);
      run_op(0, 9, 0, 0);
      run_op(11, 2, 3, 1);

      // Reset during the third BUSY cycle abandons the operation.
      in_valid = 1'b1;
      dividend = 4'd14;
      divisor  = 4'd4;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_quot", quotient, 0);
      chk("mid_rst_rem", remainder, 0);
      chk("mid_rst_dbz", div_by_zero, 0);
      run_op(9, 2, 0, 0);

      // Exhaustive sweep, operands held valid, random result stalls.
      idx = 0;
      got = 0;
      cyc = 0;
      in_valid = 1'b1;
      dividend = '0;
      divisor  = '0;
      while (got < 256 && cyc < 6000) begin
         out_ready = ($urandom_range(0, 2) != 0);
         acc = in_valid && in_ready;
         con = out_valid && out_ready;
         if (con) begin
            if (exq.size() == 0) begin
               chk("sweep_extra", 1, 0);
            end else begin
               e = exq.pop_front();
               chk("sweep_quot", quotient, e[2*W-1:W]);
               chk("sweep_rem", remainder, e[W-1:0]);
               chk("sweep_dbz", div_by_zero, e[2*W]);
            end
            got++;
         end
         if (acc) exq.push_back(ref_div(int'(dividend), int'(divisor)));
         step();
         cyc++;
         if (acc) begin
            idx++;
            if (idx < 256) begin
               dividend = W'(idx >> W);
               divisor  = W'(idx);
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      out_ready = 1'b0;
      chk("sweep_count", got, 256);
      chk("sweep_accepts", idx, 256);
      chk("sweep_left", exq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_div.md
# seq_div

Multi-cycle unsigned restoring divider built on the team's ripple-carry arithmetic. It performs the inverse of the adder's operation: one ripple-borrow trial subtraction per cycle, one quotient bit per cycle. It sits beside the adder in the arithmetic datapath. Operands enter and results leave over valid/ready handshakes.

## Interface
- WIDTH, 4, operand, quotient and remainder width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- dividend  input  WIDTH  unsigned dividend, sampled on accept
- divisor  input  WIDTH  unsigned divisor, sampled on accept
- out_valid  output  1  result valid (high only in DONE)
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  unsigned quotient
- remainder  output  WIDTH  unsigned remainder
- div_by_zero  output  1  set with result when divisor was 0

## Operation
- FSM states: IDLE, BUSY, DONE.
- Accept = in_valid & in_ready. On accept:
  - latch divisor into d_reg, dividend into q_reg;
  - clear rem_reg (WIDTH+1 bits) and cnt;
  - go to BUSY, or go straight to DONE if divisor == 0.
- BUSY step, one per cycle:
  - shifted = {rem_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  - trial = shifted − {1'b0, d_reg} via the ripple-borrow subtractor;
  - no borrow-out: rem_reg = trial, shift 1 into q_reg LSB;
  - borrow-out: rem_reg = shifted, shift 0 into q_reg LSB;
  - q_reg shifts left every step; cnt increments.
- After WIDTH steps (cnt == WIDTH−1 on the step edge), go to DONE.
- DONE:
  - quotient = q_reg, remainder = rem_reg[WIDTH-1:0];
  - hold all outputs stable until out_ready;
  - on out_valid & out_ready, go to IDLE.
- Divide by zero: quotient = all ones, remainder = dividend, div_by_zero = 1. div_by_zero is 0 for every other result.
- Arithmetic: rem_reg needs WIDTH+1 bits because the shifted partial remainder can reach 2·divisor−1. The final remainder is always < divisor and fits in WIDTH bits.
- in_ready is low in BUSY and DONE. A new operation cannot be accepted in the cycle a result is consumed; it is accepted in the next IDLE cycle.
- Operand inputs are ignored outside the accept cycle.

## Timing
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0;
  - quotient, remainder, div_by_zero = 0;
  - all internal registers 0.
- Reset in any state, including mid-BUSY or DONE with result unconsumed: the operation is abandoned and the reset values apply on the next edge. No result is emitted.
- Latency, counting the accept cycle as cycle 0:
  - normal operation: out_valid first high in cycle WIDTH+1;
  - divide by zero: out_valid high in cycle 1.
- Throughput: with out_ready held high, one result per WIDTH+2 cycles.
- in_valid may be held high in BUSY/DONE. Only the operands present in the next IDLE cycle are accepted.
- Combinational paths:
  - in_ready and out_valid decode state only;
  - no combinational path from in_valid or out_ready to any output.
- Critical path: one WIDTH+1-bit ripple-borrow chain plus a mux.

## Structure
- Shared arithmetic package holds:
  - the state enum (IDLE/BUSY/DONE);
  - a function giving the counter width, clog2(WIDTH).
- Sub-module lcs: ripple-borrow subtractor, parameter WIDTH.
  - Ports: a, b, bi → d, bo.
  - Structure mirrors the adder's generate-loop carry chain: generate = ~a & b, propagate = ~(a ^ b).
  - Instantiated once at WIDTH+1 with bi = 0.
- seq_div holds the FSM, counter and shift registers only.

## Test plan
All scenarios use WIDTH=4.
- 13 ÷ 3, out_ready high → quotient 4, remainder 1, div_by_zero 0; out_valid exactly 5 cycles after accept, for one cycle; in_ready high the following cycle.
- 7 ÷ 0 → quotient 15, remainder 7, div_by_zero 1; out_valid in the cycle after accept.
- 15 ÷ 1 → 15 r 0; 2 ÷ 5 → 0 r 2; 15 ÷ 15 → 1 r 0; 0 ÷ 9 → 0 r 0.
- 11 ÷ 2 with out_ready low for 3 cycles in DONE → 5 r 1 held stable throughout; in_ready low; in_valid pulses during DONE are ignored; IDLE follows the handshake.
- rst asserted in the 3rd BUSY cycle of 14 ÷ 4 → next cycle in_ready 1, out_valid 0, outputs 0; a following 9 ÷ 2 returns 4 r 1 with normal latency.
- Exhaustive sweep of all 256 operand pairs, back-to-back with random out_ready stalls → every result matches the reference model (/ and %, with the divide-by-zero rule); results are never duplicated or dropped.
